// File: rtl/reset_sequencer_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes, counter width.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    localparam int CNT_W = 16;

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Push-button conditioning: two-flop synchronizer, stable-count debouncer and a
// registered one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            rise_q;

    // Count consecutive samples that disagree with the accepted level; any agreeing
    // sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DB_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            rise_q  <= deb_d & ~deb_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/reset_sequencer.sv
// System reset sequencer: holds all domains in reset, then releases them in index
// order with a fixed gap; restarts on a debounced button press or a CPU soft request.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 500,
    parameter int STAGE_GAP   = 16,
    parameter int DEBOUNCE    = 250000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_in,
    input  logic                  soft_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  busy,
    output logic [1:0]            cause
);

    localparam int IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]      gap_q, gap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [1:0]            cause_q, cause_d;

    logic                  btn_evt;
    logic                  restart;
    logic [1:0]            restart_cause;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_in),
        .rise_o (btn_evt)
    );

    // Button restarts from any state and outranks a coincident soft request.
    assign restart       = btn_evt || ((state_q == ST_RUN) && soft_req);
    assign restart_cause = btn_evt ? CAUSE_BTN : CAUSE_SOFT;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        cause_d = cause_q;

        if (restart) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            cause_d = restart_cause;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d   = '0;
                        gap_d    = '0;
                        idx_d    = IDX_W'(1);
                        rst_d[0] = 1'b0;
                        if (NUM_STAGES == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        idx_d = idx_q + 1'b1;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (IDX_W'(i) == idx_q) rst_d[i] = 1'b0;
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_RUN: ;
                default: state_d = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign rst_out = rst_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD=8, GAP=4, DEBOUNCE=4.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       soft_req;
    logic [2:0] rst_out;
    logic       ready;
    logic       busy;
    logic [1:0] cause;

    int n_tests = 0;
    int n_fail  = 0;

    reset_sequencer #(
        .NUM_STAGES  (3),
        .HOLD_CYCLES (8),
        .STAGE_GAP   (4),
        .DEBOUNCE    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .soft_req (soft_req),
        .rst_out  (rst_out),
        .ready    (ready),
        .busy     (busy),
        .cause    (cause)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        btn_in   = 1'b0;
        soft_req = 1'b0;

        // Reset state
        #12;
        chk("rst_rst_out", 32'(rst_out), 32'h7);
        chk("rst_ready",   32'(ready),   32'h0);
        chk("rst_busy",    32'(busy),    32'h1);
        chk("rst_cause",   32'(cause),   32'h0);

        // 1. Power-on release: edge n means n rising edges after deassertion
        @(negedge clk);
        reset = 1'b0;
        step(7);  chk("por_n7_rst",   32'(rst_out), 32'h7);
        chk("por_n7_ready", 32'(ready), 32'h0);
        step(1);  chk("por_n8_rst",   32'(rst_out), 32'h6);
        step(3);  chk("por_n11_rst",  32'(rst_out), 32'h6);
        step(1);  chk("por_n12_rst",  32'(rst_out), 32'h4);
        step(3);  chk("por_n15_rst",  32'(rst_out), 32'h4);
        chk("por_n15_ready", 32'(ready), 32'h0);
        step(1);  chk("por_n16_rst",  32'(rst_out), 32'h0);
        chk("por_n16_ready", 32'(ready), 32'h1);
        chk("por_n16_busy",  32'(busy),  32'h0);
        chk("por_cause",     32'(cause), 32'h0);

        // 2. Soft request in RUN
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
        chk("soft_rst",   32'(rst_out), 32'h7);
        chk("soft_ready", 32'(ready),   32'h0);
        chk("soft_busy",  32'(busy),    32'h1);
        chk("soft_cause", 32'(cause),   32'h2);
        step(7);  chk("soft_n7_rst",  32'(rst_out), 32'h7);
        step(1);  chk("soft_n8_rst",  32'(rst_out), 32'h6);
        step(4);  chk("soft_n12_rst", 32'(rst_out), 32'h4);
        step(4);  chk("soft_n16_rst", 32'(rst_out), 32'h0);
        chk("soft_n16_ready", 32'(ready), 32'h1);

        // 3. Short glitch ignored; long press restarts exactly once
        btn_in = 1'b1;
        step(3);
        btn_in = 1'b0;
        step(10);
        chk("glitch_ready", 32'(ready), 32'h1);
        chk("glitch_cause", 32'(cause), 32'h2);
        btn_in = 1'b1;
        step(6);  chk("btn_pre_ready", 32'(ready), 32'h1);
        step(1);  chk("btn_rst",   32'(rst_out), 32'h7);
        chk("btn_cause", 32'(cause), 32'h1);
        step(16); chk("btn_n16_ready", 32'(ready), 32'h1);
        step(77); chk("btn_held_ready", 32'(ready), 32'h1);
        chk("btn_held_rst", 32'(rst_out), 32'h0);
        btn_in = 1'b0;
        step(10); chk("btn_release_ready", 32'(ready), 32'h1);

        // 4. Coincident button and soft request; soft request during HOLD
        btn_in = 1'b1;
        step(6);
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
        btn_in   = 1'b0;
        chk("both_rst",   32'(rst_out), 32'h7);
        chk("both_cause", 32'(cause),   32'h1);
        step(2);
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
        chk("hold_soft_rst",   32'(rst_out), 32'h7);
        chk("hold_soft_cause", 32'(cause),   32'h1);
        step(12); chk("hold_soft_n15_rst",   32'(rst_out), 32'h4);
        chk("hold_soft_n15_ready", 32'(ready), 32'h0);
        step(1);  chk("hold_soft_n16_ready", 32'(ready), 32'h1);

        // 5. Button event during RELEASE
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
        step(7);
        btn_in = 1'b1;
        step(6);  chk("rel_n13_rst", 32'(rst_out), 32'h4);
        step(1);  chk("rel_n14_rst", 32'(rst_out), 32'h7);
        chk("rel_cause", 32'(cause), 32'h1);
        step(3);
        btn_in = 1'b0;
        step(4);  chk("rel_hold7_rst", 32'(rst_out), 32'h7);
        step(1);  chk("rel_hold8_rst", 32'(rst_out), 32'h6);

        // 6. Asynchronous reset between edges mid-RELEASE
        step(2);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst",   32'(rst_out), 32'h7);
        chk("async_ready", 32'(ready),   32'h0);
        chk("async_busy",  32'(busy),    32'h1);
        chk("async_cause", 32'(cause),   32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(8);  chk("async_n8_rst", 32'(rst_out), 32'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
